// File: rtl/complement2_encode_serial_pkg.sv
// Shared calculator definitions: FSM state encoding, default operand width,
// and the bit-counter width helper.
package calc_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_t;

   // Width of a counter that indexes bits 0..w-1 (never below one bit).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/complement2_encode_serial_if.sv
// sel/finish handshake bundle for the two's-complement encode stage.
interface complement2_encode_serial_if
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             complement2_sel;
   logic             sign;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             busy;
   logic             complement2_finish;

   modport master (
      output complement2_sel, sign, mag,
      input  result, overflow, busy, complement2_finish
   );

   modport slave (
      input  complement2_sel, sign, mag,
      output result, overflow, busy, complement2_finish
   );

endinterface

// File: rtl/complement2_encode_serial_full_adder.sv
// Single-bit full adder shared by the calculator arithmetic stages.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic co
);

   // Plain combinational sum/carry.
   always_comb begin
      sum = a ^ b ^ ci;
      co  = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/complement2_encode_serial.sv
// Sign + magnitude to two's-complement encoder. Negative values are built
// LSB first through one full adder (invert and increment); non-negative
// values and zero bypass the serial path and finish in one cycle.
module complement2_encode_serial
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   complement2_encode_serial_if.slave        bus
);

   localparam int unsigned        CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;     // magnitude, consumed LSB first
   logic [WIDTH-1:0]   acc_q, acc_d;         // result bits, filled from MSB side
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               overflow_q, overflow_d;
   logic               finish_q, finish_d;

   logic               fa_a;
   logic               fa_sum;
   logic               fa_co;

   assign fa_a = ~shift_q[0];

   full_adder u_fa (
      .a   (fa_a),
      .b   (1'b0),
      .ci  (carry_q),
      .sum (fa_sum),
      .co  (fa_co)
   );

   // Next-state, datapath and completion logic.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      finish_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.complement2_sel) begin
               if (bus.sign && (bus.mag != '0)) begin
                  shift_d    = bus.mag;
                  acc_d      = '0;
                  carry_d    = 1'b1;
                  cnt_d      = '0;
                  // Only -2^(WIDTH-1) fits; anything larger wraps.
                  ovf_pend_d = bus.mag[WIDTH-1] && (bus.mag[WIDTH-2:0] != '0);
                  state_d    = CONVERT;
               end else begin
                  result_d   = bus.mag;
                  overflow_d = ~bus.sign & bus.mag[WIDTH-1];
                  finish_d   = 1'b1;
               end
            end
         end
         CONVERT: begin
            acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
            shift_d = shift_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               result_d   = {fa_sum, acc_q[WIDTH-1:1]};
               overflow_d = ovf_pend_q;
               finish_d   = 1'b1;
               state_d    = IDLE;
            end
         end
      endcase
   end

   // State and datapath registers, cleared by asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         finish_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         finish_q   <= finish_d;
      end
   end

   assign bus.result             = result_q;
   assign bus.overflow           = overflow_q;
   assign bus.busy               = (state_q == CONVERT);
   assign bus.complement2_finish = finish_q;

endmodule

// File: tb/tb_complement2_encode_serial.sv
// Scoreboard bench for complement2_encode_serial (WIDTH = 4).
module tb_complement2_encode_serial;

   localparam int unsigned W = 4;

   typedef struct {
      logic [3:0] res;
      logic       ovf;
      int         edge_no;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   ecount = 0;
   int   passed = 0;
   int   total  = 0;
   exp_t sb_q[$];

   complement2_encode_serial_if #(.WIDTH(W)) bus ();

   complement2_encode_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
   endtask

   function automatic exp_t push_exp(input logic [3:0] r, input logic o, input int e);
      exp_t x;
      x.res = r; x.ovf = o; x.edge_no = e;
      return x;
   endfunction

   // Independent reference: signed value, then range test and truncation.
   function automatic logic [4:0] ref_model(input logic s, input logic [3:0] m);
      int         v;
      logic       o;
      logic [3:0] r;
      v = s ? -int'(m) : int'(m);
      o = (v > 7) || (v < -8);
      r = 4'(v);
      return {o, r};
   endfunction

   // Monitor: every finish pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (bus.complement2_finish === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_finish", 1, 0);
         end else begin
            exp_t x;
            x = sb_q.pop_front();
            check("result",      int'(bus.result),   int'(x.res));
            check("overflow",    int'(bus.overflow), int'(x.ovf));
            check("finish_edge", ecount,             x.edge_no);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy === 1'b1; i++) @(negedge clk);
      if (bus.busy !== 1'b0) check("busy_timeout", 1, 0);
   endtask

   // Called at a negedge with the DUT idle; one-cycle sel pulse.
   task automatic issue(input logic s, input logic [3:0] m,
                        input logic [3:0] er, input logic eo);
      int k;
      k = ecount + 1;
      bus.sign = s; bus.mag = m; bus.complement2_sel = 1'b1;
      sb_q.push_back(push_exp(er, eo, (s && m != 0) ? k + int'(W) : k));
      @(negedge clk);
      bus.complement2_sel = 1'b0;
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [4:0] rm;
      bus.complement2_sel = 1'b0; bus.sign = 1'b0; bus.mag = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_result",   int'(bus.result),             0);
      check("rst_overflow", int'(bus.overflow),           0);
      check("rst_busy",     int'(bus.busy),               0);
      check("rst_finish",   int'(bus.complement2_finish), 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: -3 serial, busy for four cycles, finish WIDTH edges after sel.
      k = ecount + 1;
      bus.sign = 1'b1; bus.mag = 4'd3; bus.complement2_sel = 1'b1;
      sb_q.push_back(push_exp(4'b1101, 1'b0, k + 4));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.complement2_sel = 1'b0;
         check("busy_high", int'(bus.busy), 1);
      end
      @(negedge clk);
      check("busy_low", int'(bus.busy), 0);

      // 2: bypass non-negative, including positive overflow.
      issue(1'b0, 4'd5, 4'b0101, 1'b0);
      issue(1'b0, 4'd9, 4'b1001, 1'b1);

      // 3: most negative, negative overflow, negative zero.
      issue(1'b1, 4'd8, 4'b1000, 1'b0);
      issue(1'b1, 4'd9, 4'b0111, 1'b1);
      issue(1'b1, 4'd0, 4'b0000, 1'b0);

      // 4: sel and mag activity while busy is ignored.
      k = ecount + 1;
      bus.sign = 1'b1; bus.mag = 4'd6; bus.complement2_sel = 1'b1;
      sb_q.push_back(push_exp(4'b1010, 1'b0, k + 4));
      @(negedge clk); bus.complement2_sel = 1'b0; bus.mag = 4'd1;
      @(negedge clk); bus.complement2_sel = 1'b1; bus.sign = 1'b0;
      @(negedge clk); bus.complement2_sel = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      // 5: reset mid-conversion aborts silently.
      bus.sign = 1'b1; bus.mag = 4'd5; bus.complement2_sel = 1'b1;
      @(negedge clk); bus.complement2_sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_result",   int'(bus.result),             0);
      check("abort_overflow", int'(bus.overflow),           0);
      check("abort_busy",     int'(bus.busy),               0);
      check("abort_finish",   int'(bus.complement2_finish), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("post_abort_result", int'(bus.result), 0);
      issue(1'b1, 4'd1, 4'b1111, 1'b0);

      // 6a: sel held high for three serial requests, WIDTH+1 apart.
      k = ecount + 1;
      bus.sign = 1'b1; bus.mag = 4'd3; bus.complement2_sel = 1'b1;
      sb_q.push_back(push_exp(4'b1101, 1'b0, k + 4));
      sb_q.push_back(push_exp(4'b1010, 1'b0, k + 9));
      sb_q.push_back(push_exp(4'b1001, 1'b0, k + 14));
      @(negedge clk); bus.mag = 4'd6;
      repeat (5) @(negedge clk); bus.mag = 4'd7;
      repeat (5) @(negedge clk); bus.complement2_sel = 1'b0;
      wait_idle();

      // 6b: held sel on bypass gives back-to-back finish pulses.
      k = ecount + 1;
      bus.sign = 1'b0; bus.mag = 4'd2; bus.complement2_sel = 1'b1;
      sb_q.push_back(push_exp(4'b0010, 1'b0, k));
      sb_q.push_back(push_exp(4'b0100, 1'b0, k + 1));
      @(negedge clk); bus.mag = 4'd4;
      @(negedge clk); bus.complement2_sel = 1'b0;
      @(negedge clk);

      // 6c: all sign/magnitude combinations against the reference model.
      for (int s = 0; s < 2; s++) begin
         for (int m = 0; m < 16; m++) begin
            rm = ref_model(s[0], 4'(m));
            issue(s[0], 4'(m), rm[3:0], rm[4]);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
